seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DWELL_CYC, default 100000, SHALL set clock cycles each digit is lit per slot (minimum 1).
REQ-002 Parameter BLANK_CYC, default 1000, SHALL set clock cycles all anodes are off before each digit (anti-ghosting; minimum 1).
REQ-003 CLK100MHZ  in  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 RST  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 VALUE  in  32  SHALL carry eight hex nibbles; nibble k drives digit k (digit 0 rightmost).
REQ-006 DP_IN  in  8  SHALL carry the decimal-point request per digit, active-high.
REQ-007 DIG_EN  in  8  SHALL carry the per-digit enable mask, active-high.
REQ-008 LOAD  in  1  SHALL be a one-cycle strobe capturing VALUE/DP_IN/DIG_EN into the pending registers.
REQ-009 AN  out  8  SHALL carry the digit anodes, active-low, at most one low at any time.
REQ-010 CA..CG  out  1 each  SHALL carry the segment cathodes, active-low.
REQ-011 DP  out  1  SHALL carry the decimal-point cathode, active-low.
REQ-012 FRAME_DONE  out  1  SHALL pulse high for one cycle on the last cycle of digit 7's SHOW slot.

Function
REQ-013 FSM states SHALL be IDLE, BLANK, SHOW.
REQ-014 IDLE SHALL last exactly one cycle after reset release, then go to BLANK with index 0.
REQ-015 BLANK SHALL hold AN=8'hFF and CA..CG, DP=1 for BLANK_CYC cycles, then go to SHOW.
REQ-016 SHOW SHALL last DWELL_CYC cycles with AN[index]=0 if the displayed DIG_EN[index]=1, else AN=8'hFF.
REQ-017 At the end of SHOW, the index SHALL increment modulo 8 (7 wraps to 0) and the FSM SHALL return to BLANK.
REQ-018 A slot SHALL be BLANK_CYC+DWELL_CYC cycles; a frame SHALL be 8 slots, with disabled digits keeping their timing.
REQ-019 Segments SHALL be registered hex decode of the displayed nibble, gfedcba order, active-low; 0 -> CA..CF=0, CG=1; 8 -> all 0; F -> CA,CE,CF,CG=0.
REQ-020 DP SHALL equal ~DP_IN[index] of the displayed set during SHOW.
REQ-021 LOAD SHALL write pending registers in the next cycle; the last LOAD before a frame boundary wins.
REQ-022 Pending-to-displayed transfer SHALL occur only on entering BLANK for index 0, so a frame never mixes old and new data.
REQ-023 LOAD coincident with the frame-boundary transfer SHALL be applied at the following boundary; the current transfer uses the prior pending value.
REQ-024 Outputs SHALL be registered with no combinational input-to-output path; a LOAD changes AN/segments no earlier than the next frame.
REQ-025 The dwell and blank counters SHALL be sized $clog2 of the larger parameter and SHALL never wrap within a state.

Reset
REQ-026 Reset SHALL set: AN=8'hFF, CA..CG=1, DP=1, FRAME_DONE=0, state=IDLE, index=0, counters=0, pending and displayed VALUE=0, DP=0, DIG_EN=8'h00.
REQ-027 Reset asserted mid-slot SHALL blank all outputs asynchronously within the same cycle, discarding any pending LOAD.

Configuration
REQ-028 With SEG7_LEADING_ZERO_BLANK_EN defined, enabled digits above the highest nonzero nibble SHALL be treated as disabled (AN high); digit 0 always shows; DP_IN is ignored for suppressed digits.
REQ-029 Without SEG7_LEADING_ZERO_BLANK_EN, all enabled digits SHALL display their nibble, including zeros.

Structure
REQ-030 Package seg7_pkg SHALL hold the state enum, the 16-entry active-low segment constant table, and NUM_DIGITS=8.
REQ-031 Sub-module seg7_hex_decode (4-bit in, 7-bit active-low out, combinational) SHALL be instantiated once; the caller registers its output.

Verification (DWELL_CYC=4, BLANK_CYC=1)
REQ-032 Reset, then LOAD VALUE=32'h0000_0000, DIG_EN=8'h01 -> first full frame shows AN=8'hFE only in slot 0, CA..CG=0000001, and FRAME_DONE pulses every 40 cycles.
REQ-033 LOAD VALUE=32'h8765_4321, DIG_EN=8'hFF, DP_IN=8'h04 -> slot 2 shows AN=8'hFB, digit "3", DP=0; all other slots show DP=1; each BLANK cycle shows AN=8'hFF.
REQ-034 LOAD 32'h1111_1111 mid-frame at slot 3 -> the remainder of the frame keeps the old value; the new value appears starting at the next slot 0.
REQ-035 LOAD on the exact cycle of the frame-boundary transfer -> the new value appears one frame later.
REQ-036 Assert RST during SHOW of slot 5 -> AN=8'hFF in the same cycle; after release: one IDLE cycle, then slot 0 with displayed DIG_EN=0, so all slots are dark.
REQ-037 With the macro, VALUE=32'h0000_00A0, DIG_EN=8'hFF -> only digits 0 and 1 are lit, showing "0" and "A".

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit seven-segment scan controller:
// scan states, digit count and the active-low hex segment table.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the active-low pattern for hex digit n, bit order gfedcba.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low gfedcba segment decode.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_LUT[i_nib];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scanner with blanking gaps and
// frame-atomic data updates. Optional SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DWELL_CYC = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        RST,
  input  logic [31:0] VALUE,
  input  logic [7:0]  DP_IN,
  input  logic [7:0]  DIG_EN,
  input  logic        LOAD,
  output logic [7:0]  AN,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic        FRAME_DONE
);

  localparam int unsigned MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_xfer;

  logic [31:0]     r_pend_val, r_disp_val;
  logic [7:0]      r_pend_dp,  r_disp_dp;
  logic [7:0]      r_pend_en,  r_disp_en;

  logic [7:0]      w_lz_mask;
  logic [7:0]      w_en_eff, w_dp_eff;
  logic [3:0]      w_nib;
  logic [6:0]      w_seg_dec;
  logic            w_show_nxt;

  logic [7:0]      w_an_nxt;
  logic [6:0]      w_seg_nxt;
  logic            w_dp_nxt, w_fd_nxt;

  logic [7:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp, r_fd;

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_xfer      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_BLANK;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
        w_xfer      = 1'b1;
      end
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_SHOW: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = r_idx + 3'd1;
          w_cnt_nxt   = '0;
          w_xfer      = (r_idx == LAST_IDX);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pending set is latched on LOAD; displayed set only changes when entering
  // BLANK of digit 0, so a LOAD on that same edge waits for the next frame.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_en  <= '0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_disp_en  <= '0;
    end else begin
      if (LOAD) begin
        r_pend_val <= VALUE;
        r_pend_dp  <= DP_IN;
        r_pend_en  <= DIG_EN;
      end
      if (w_xfer) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
        r_disp_en  <= r_pend_en;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    w_lz_mask    = '0;
    w_lz_mask[0] = 1'b1;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      w_lz_mask[k] = |(r_disp_val >> (4 * k));
    end
  end
`else
  always_comb begin
    w_lz_mask = '1;
  end
`endif

  always_comb begin
    w_en_eff   = r_disp_en & w_lz_mask;
    w_dp_eff   = r_disp_dp & w_lz_mask;
    w_nib      = r_disp_val[{w_idx_nxt, 2'b00} +: 4];
    w_show_nxt = (w_state_nxt == ST_SHOW);
  end

  seg7_hex_decode u_hex_decode (
    .i_nib   (w_nib),
    .o_seg_n (w_seg_dec)
  );

  // Outputs are computed from next-state so the registered pins line up
  // with the state they describe, with no input-to-pin combinational path.
  always_comb begin
    w_an_nxt = '1;
    if (w_show_nxt && w_en_eff[w_idx_nxt]) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
    end
    w_seg_nxt = w_show_nxt ? w_seg_dec : SEG_BLANK;
    w_dp_nxt  = ~(w_show_nxt & w_dp_eff[w_idx_nxt]);
    w_fd_nxt  = w_show_nxt && (w_idx_nxt == LAST_IDX) && (w_cnt_nxt == DWELL_LAST);
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_fd  <= 1'b0;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
      r_fd  <= w_fd_nxt;
    end
  end

  assign AN         = r_an;
  assign {CG, CF, CE, CD, CC, CB, CA} = r_seg;
  assign DP         = r_dp;
  assign FRAME_DONE = r_fd;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DWELL_CYC=4, BLANK_CYC=1 (5-cycle slot,
// 40-cycle frame). Leading-zero expectations follow SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        RST;
  logic [31:0] VALUE;
  logic [7:0]  DP_IN;
  logic [7:0]  DIG_EN;
  logic        LOAD;
  logic [7:0]  AN;
  logic        CA, CB, CC, CD, CE, CF, CG;
  logic        DP;
  logic        FRAME_DONE;

  int vecs = 0;
  int errs = 0;

  logic [7:0] cap_an  [1:40];
  logic [6:0] cap_seg [1:40];
  logic       cap_dp  [1:40];

  seg7_scan_ctrl #(.DWELL_CYC(4), .BLANK_CYC(1)) dut (
    .CLK100MHZ  (clk),
    .RST        (RST),
    .VALUE      (VALUE),
    .DP_IN      (DP_IN),
    .DIG_EN     (DIG_EN),
    .LOAD       (LOAD),
    .AN         (AN),
    .CA         (CA),
    .CB         (CB),
    .CC         (CC),
    .CD         (CD),
    .CE         (CE),
    .CF         (CF),
    .CG         (CG),
    .DP         (DP),
    .FRAME_DONE (FRAME_DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment pattern in {CA,CB,CC,CD,CE,CF,CG} order, active-low.
  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks cycles j=1..last_j of a frame (j=1 is BLANK of digit 0); optionally
  // pulses LOAD with new data right after the check at cycle ld_j.
  task automatic run_frame(input string name, input logic [31:0] val, input logic [7:0] en,
                           input logic [7:0] dpin, input int ld_j, input logic [31:0] ld_val,
                           input logic [7:0] ld_en, input logic [7:0] ld_dp, input int last_j);
    int         hi;
    logic [7:0] shown_ok;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fd;
    logic [6:0] obs_seg;
    logic [3:0] nib;
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      if (((val >> (4 * k)) & 32'hF) != 32'h0) hi = k;
    end
    for (int k = 0; k < 8; k++) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      shown_ok[k] = (k <= hi);
`else
      shown_ok[k] = 1'b1;
`endif
    end
    for (int j = 1; j <= last_j; j++) begin
      int s;
      int ph;
      @(negedge clk);
      LOAD = 1'b0;
      s  = (j - 1) / 5;
      ph = (j - 1) % 5;
      exp_fd = (j == 40);
      if (ph == 0) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        nib     = 4'((val >> (4 * s)) & 32'hF);
        exp_an  = 8'hFF;
        if (en[s] && shown_ok[s]) exp_an[s] = 1'b0;
        exp_seg = seg_ref(nib);
        exp_dp  = shown_ok[s] ? ~dpin[s] : 1'b1;
      end
      obs_seg = {CA, CB, CC, CD, CE, CF, CG};
      cap_an[j]  = AN;
      cap_seg[j] = obs_seg;
      cap_dp[j]  = DP;
      chk($sformatf("%s j%0d", name, j), {15'd0, AN, obs_seg, DP, FRAME_DONE},
          {15'd0, exp_an, exp_seg, exp_dp, exp_fd});
      if (j == ld_j) begin
        VALUE  = ld_val;
        DIG_EN = ld_en;
        DP_IN  = ld_dp;
        LOAD   = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST    = 1'b1;
    LOAD   = 1'b0;
    VALUE  = '0;
    DP_IN  = '0;
    DIG_EN = '0;
    repeat (3) @(negedge clk);
    chk("reset_an",  {24'd0, AN}, 32'hFF);
    chk("reset_seg", {25'd0, CA, CB, CC, CD, CE, CF, CG}, 32'h7F);
    chk("reset_dp",  {31'd0, DP}, 32'h1);
    chk("reset_fd",  {31'd0, FRAME_DONE}, 32'h0);
    RST = 1'b0;
    chk("idle_an", {24'd0, AN}, 32'hFF);

    // Frame 0 dark; load digit-0-only zero display for frame 1.
    run_frame("f0", 32'h0, 8'h00, 8'h00, 5, 32'h0000_0000, 8'h01, 8'h00, 40);
    run_frame("f1", 32'h0, 8'h01, 8'h00, 10, 32'h8765_4321, 8'hFF, 8'h04, 40);
    chk("f1_slot0_an",  {24'd0, cap_an[2]},  32'hFE);
    chk("f1_slot0_seg", {25'd0, cap_seg[2]}, 32'h01);
    chk("f1_slot1_an",  {24'd0, cap_an[7]},  32'hFF);

    // Mid-frame LOAD at slot 3 must not disturb the rest of this frame.
    run_frame("f2", 32'h8765_4321, 8'hFF, 8'h04, 16, 32'h1111_1111, 8'hFF, 8'h00, 40);
    chk("f2_slot2_an",    {24'd0, cap_an[12]},  32'hFB);
    chk("f2_slot2_seg",   {25'd0, cap_seg[12]}, 32'h06);
    chk("f2_slot2_dp",    {31'd0, cap_dp[12]},  32'h0);
    chk("f2_slot1_dp",    {31'd0, cap_dp[7]},   32'h1);
    chk("f2_blank2_an",   {24'd0, cap_an[11]},  32'hFF);
    chk("f2_slot7_seg",   {25'd0, cap_seg[37]}, 32'h00);

    // LOAD on the boundary cycle lands one frame later.
    run_frame("f3", 32'h1111_1111, 8'hFF, 8'h00, 40, 32'hCAFE_0009, 8'hFF, 8'h80, 40);
    run_frame("f4", 32'h1111_1111, 8'hFF, 8'h00, 0, 32'h0, 8'h00, 8'h00, 40);
    run_frame("f5", 32'hCAFE_0009, 8'hFF, 8'h80, 0, 32'h0, 8'h00, 8'h00, 40);
    chk("f5_slot7_an",  {24'd0, cap_an[37]},  32'h7F);
    chk("f5_slot7_seg", {25'd0, cap_seg[37]}, 32'h31);
    chk("f5_slot7_dp",  {31'd0, cap_dp[37]},  32'h0);
    chk("f5_slot0_seg", {25'd0, cap_seg[2]},  32'h04);

    // Reset in SHOW of slot 5, with a pending LOAD that must be discarded.
    run_frame("f6", 32'hCAFE_0009, 8'hFF, 8'h80, 10, 32'hFFFF_FFFF, 8'hFF, 8'hFF, 28);
    RST = 1'b1;
    #1;
    chk("rst_async_an",  {24'd0, AN}, 32'hFF);
    chk("rst_async_seg", {25'd0, CA, CB, CC, CD, CE, CF, CG}, 32'h7F);
    chk("rst_async_dp",  {31'd0, DP}, 32'h1);
    chk("rst_async_fd",  {31'd0, FRAME_DONE}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0;
    chk("idle2_an", {24'd0, AN}, 32'hFF);

    run_frame("f7", 32'h0, 8'h00, 8'h00, 3, 32'h0000_00A0, 8'hFF, 8'hFF, 40);
    run_frame("f8", 32'h0000_00A0, 8'hFF, 8'hFF, 0, 32'h0, 8'h00, 8'h00, 40);
    chk("f8_slot0_an",  {24'd0, cap_an[2]},  32'hFE);
    chk("f8_slot0_seg", {25'd0, cap_seg[2]}, 32'h01);
    chk("f8_slot1_an",  {24'd0, cap_an[7]},  32'hFD);
    chk("f8_slot1_seg", {25'd0, cap_seg[7]}, 32'h08);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("f8_slot2_an",  {24'd0, cap_an[12]}, 32'hFF);
    chk("f8_slot2_dp",  {31'd0, cap_dp[12]}, 32'h1);
    chk("f8_slot7_an",  {24'd0, cap_an[37]}, 32'hFF);
`else
    chk("f8_slot2_an",  {24'd0, cap_an[12]}, 32'hFB);
    chk("f8_slot2_dp",  {31'd0, cap_dp[12]}, 32'h0);
    chk("f8_slot7_an",  {24'd0, cap_an[37]}, 32'h7F);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
